// File: rtl/axil_simp_master.sv
// -----------------------------------------------------------------------------
// axil_simp_master
//
// Purpose:
//   Slave end of the simple exec/we/fin driver handshake. Each command
//   (address, data, we) sampled while exec=1 in IDLE becomes one single-beat
//   AXI4-Lite write or read on the master port. Completion is reported with a
//   four-phase fin level; read data is returned on so_data.
//
// Optional build macro:
//   AXIL_SIMP_RESP_ERR_EN - adds the 2-bit resp_err output carrying the
//                           BRESP/RRESP of the last completed command.
//
// Ports:
//   clk, nreset         clock and synchronous active-low reset
//   si_address, si_data command address and write data
//   we, exec            1 = write / 0 = read, command request (level)
//   so_data             read data of the last completed read
//   fin                 command complete (level, held until exec drops)
//   m_axi_aw*/w*/b*     AXI4-Lite write address, write data, write response
//   m_axi_ar*/r*        AXI4-Lite read address, read data
//   resp_err            (optional) response code of the last completion
// -----------------------------------------------------------------------------
module axil_simp_master #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   si_address,
  input  logic [C_AXI_DATA_WIDTH-1:0]   si_data,
  output logic [C_AXI_DATA_WIDTH-1:0]   so_data,
  input  logic                          we,
  input  logic                          exec,
  output logic                          fin,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
`ifdef AXIL_SIMP_RESP_ERR_EN
  ,
  output logic [1:0]                    resp_err
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                        state_reg, state_next;
  logic [C_AXI_ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [C_AXI_DATA_WIDTH-1:0]   data_reg, data_next;
  logic [C_AXI_DATA_WIDTH-1:0]   so_data_reg, so_data_next;
  logic                          awvalid_reg, awvalid_next;
  logic                          wvalid_reg, wvalid_next;
  logic                          bready_reg, bready_next;
  logic                          arvalid_reg, arvalid_next;
  logic                          rready_reg, rready_next;
  logic                          fin_reg, fin_next;

`ifdef AXIL_SIMP_RESP_ERR_EN
  logic [1:0]                    resp_err_reg, resp_err_next;
`else
  // Response codes have no consumer in this build.
  logic                          unused_resp;
  assign unused_resp = ^{m_axi_bresp, m_axi_rresp};
`endif

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      data_reg    <= '0;
      so_data_reg <= '0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      fin_reg     <= 1'b0;
`ifdef AXIL_SIMP_RESP_ERR_EN
      resp_err_reg <= 2'b00;
`endif
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      so_data_reg <= so_data_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      bready_reg  <= bready_next;
      arvalid_reg <= arvalid_next;
      rready_reg  <= rready_next;
      fin_reg     <= fin_next;
`ifdef AXIL_SIMP_RESP_ERR_EN
      resp_err_reg <= resp_err_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    so_data_next = so_data_reg;
    awvalid_next = awvalid_reg;
    wvalid_next  = wvalid_reg;
    bready_next  = bready_reg;
    arvalid_next = arvalid_reg;
    rready_next  = rready_reg;
    fin_next     = fin_reg;
`ifdef AXIL_SIMP_RESP_ERR_EN
    resp_err_next = resp_err_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (exec) begin
          addr_next = si_address;
          data_next = si_data;
          if (we) begin
            state_next   = WR_REQ;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
          end else begin
            state_next   = RD_REQ;
            arvalid_next = 1'b1;
          end
        end
      end

      WR_REQ: begin
        // AW and W complete independently; a channel whose valid is already
        // low has finished its handshake on an earlier edge.
        if (m_axi_awready) awvalid_next = 1'b0;
        if (m_axi_wready)  wvalid_next  = 1'b0;
        if ((!awvalid_reg || m_axi_awready) && (!wvalid_reg || m_axi_wready)) begin
          state_next  = WR_RESP;
          bready_next = 1'b1;
        end
      end

      WR_RESP: begin
        if (m_axi_bvalid) begin
          state_next  = DONE;
          bready_next = 1'b0;
          fin_next    = 1'b1;
`ifdef AXIL_SIMP_RESP_ERR_EN
          resp_err_next = m_axi_bresp;
`endif
        end
      end

      RD_REQ: begin
        if (m_axi_arready) begin
          state_next   = RD_RESP;
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
        end
      end

      RD_RESP: begin
        if (m_axi_rvalid) begin
          state_next   = DONE;
          so_data_next = m_axi_rdata;
          rready_next  = 1'b0;
          fin_next     = 1'b1;
`ifdef AXIL_SIMP_RESP_ERR_EN
          resp_err_next = m_axi_rresp;
`endif
        end
      end

      DONE: begin
        // fin holds until the requester withdraws exec.
        if (!exec) begin
          state_next = IDLE;
          fin_next   = 1'b0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign so_data       = so_data_reg;
  assign fin           = fin_reg;
  assign m_axi_awaddr  = addr_reg;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_reg;
  assign m_axi_wdata   = data_reg;
  assign m_axi_wstrb   = {(C_AXI_DATA_WIDTH/8){1'b1}};
  assign m_axi_wvalid  = wvalid_reg;
  assign m_axi_bready  = bready_reg;
  assign m_axi_araddr  = addr_reg;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_reg;
  assign m_axi_rready  = rready_reg;
`ifdef AXIL_SIMP_RESP_ERR_EN
  assign resp_err      = resp_err_reg;
`endif

endmodule

// File: tb/tb_axil_simp_master.sv
// -----------------------------------------------------------------------------
// tb_axil_simp_master
//
// Directed bench for axil_simp_master: a behavioural AXI4-Lite slave with
// per-channel programmable delays, a protocol monitor, and one task per
// scenario. Define AXIL_SIMP_RESP_ERR_EN to also exercise resp_err.
// -----------------------------------------------------------------------------
module tb_axil_simp_master;
  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          nreset;
  logic [AW-1:0] si_address;
  logic [DW-1:0] si_data;
  logic [DW-1:0] so_data;
  logic          we, exec, fin;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]    bresp, rresp;
`ifdef AXIL_SIMP_RESP_ERR_EN
  logic [1:0]    resp_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axil_simp_master #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW)) dut (
    .clk(clk), .nreset(nreset),
    .si_address(si_address), .si_data(si_data), .so_data(so_data),
    .we(we), .exec(exec), .fin(fin),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
`ifdef AXIL_SIMP_RESP_ERR_EN
    , .resp_err(resp_err)
`endif
  );

  // ---------------- behavioural slave ----------------
  // *_d : cycles a valid stays high before ready (1 = immediate).
  // b_d/r_d : extra cycles before the response valid appears.
  int aw_d = 1, w_d = 1, ar_d = 1, b_d = 0, r_d = 0;
  logic [1:0] bresp_val = 2'b00, rresp_val = 2'b00;
  logic [DW-1:0] mem [256];

  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic aw_done, w_done, b_pend, r_pend;
  logic [AW-1:0] cap_awaddr;
  logic [DW-1:0] cap_wdata, rdata_q;
  logic [DW/8-1:0] cap_wstrb;
  int b_hs = 0;

  assign awready = awvalid && (aw_cnt == aw_d - 1);
  assign wready  = wvalid  && (w_cnt  == w_d  - 1);
  assign arready = arvalid && (ar_cnt == ar_d - 1);
  assign bvalid  = b_pend && (b_cnt == 0);
  assign rvalid  = r_pend && (r_cnt == 0);
  assign bresp   = bresp_val;
  assign rresp   = rresp_val;
  assign rdata   = rdata_q;

  always @(posedge clk) begin
    if (!nreset) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_done <= 1'b0; w_done <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (awvalid && awready) begin
        aw_cnt <= 0; aw_done <= 1'b1; cap_awaddr <= awaddr;
      end else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin
        w_cnt <= 0; w_done <= 1'b1; cap_wdata <= wdata; cap_wstrb <= wstrb;
      end else if (wvalid) w_cnt <= w_cnt + 1;
      if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready)) && !b_pend) begin
        b_pend <= 1'b1; b_cnt <= b_d; aw_done <= 1'b0; w_done <= 1'b0;
      end else if (b_pend && b_cnt > 0) b_cnt <= b_cnt - 1;
      if (bvalid && bready) begin
        b_pend <= 1'b0; b_hs <= b_hs + 1; mem[cap_awaddr] <= cap_wdata;
      end
      if (arvalid && arready) begin
        ar_cnt <= 0; r_pend <= 1'b1; r_cnt <= r_d; rdata_q <= mem[araddr];
      end else begin
        if (arvalid) ar_cnt <= ar_cnt + 1;
        if (r_pend && r_cnt > 0) r_cnt <= r_cnt - 1;
      end
      if (rvalid && rready) r_pend <= 1'b0;
    end
  end

  // ---------------- protocol monitor ----------------
  int aw_hi = 0, w_hi = 0, bready_hi = 0, rready_hi = 0, early_bready = 0, valid_drop = 0;
  logic p_aw, p_awr, p_w, p_wr, p_ar, p_arr;

  always @(posedge clk) begin
    if (!nreset) begin
      p_aw <= 1'b0; p_awr <= 1'b0; p_w <= 1'b0; p_wr <= 1'b0; p_ar <= 1'b0; p_arr <= 1'b0;
    end else begin
      if (awvalid) aw_hi <= aw_hi + 1;
      if (wvalid)  w_hi  <= w_hi + 1;
      if (bready)  bready_hi <= bready_hi + 1;
      if (rready)  rready_hi <= rready_hi + 1;
      if (bready && (awvalid || wvalid)) early_bready <= early_bready + 1;
      if ((p_aw && !p_awr && !awvalid) || (p_w && !p_wr && !wvalid) || (p_ar && !p_arr && !arvalid))
        valid_drop <= valid_drop + 1;
      p_aw <= awvalid; p_awr <= awready; p_w <= wvalid; p_wr <= wready; p_ar <= arvalid; p_arr <= arready;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Issues one command; edges counts rising edges from (and including) the
  // one that samples exec=1 up to the one that raises fin; -1 on timeout.
  task automatic run_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w,
                         output int edges);
    @(negedge clk);
    si_address = a; si_data = d; we = w; exec = 1'b1;
    edges = 0;
    while (!fin && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        si_address = 8'hFF; si_data = 32'h0; we = ~w;  // must be ignored now
      end
    end
    if (!fin) edges = -1;
  endtask

  // Drops exec and returns fin one edge later.
  task automatic release_exec(output logic f);
    exec = 1'b0;
    @(posedge clk); #1;
    f = fin;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nreset = 1'b0; exec = 1'b0; we = 1'b0; si_address = '0; si_data = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({awvalid, wvalid, arvalid, bready, rready, fin} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000", {awvalid, wvalid, arvalid, bready, rready, fin});
    end
    total++; if (so_data !== 32'h0) begin bad++; $display("FAIL reset_so_data: got %h want 0", so_data); end
    total++; if (awaddr !== 8'h0 || wdata !== 32'h0 || araddr !== 8'h0) begin
      bad++; $display("FAIL reset_addr_data: awaddr=%h wdata=%h araddr=%h want 0", awaddr, wdata, araddr);
    end
    total++; if (awprot !== 3'b000 || arprot !== 3'b000 || wstrb !== 4'hF) begin
      bad++; $display("FAIL reset_const: awprot=%b arprot=%b wstrb=%h want 000 000 f", awprot, arprot, wstrb);
    end
    @(negedge clk); nreset = 1'b1;
    $display("reset: done");
  endtask

  task automatic test_write();
    int e; logic f; int aw0, bh0;
    aw0 = aw_hi; bh0 = b_hs;
    run_cmd(8'h04, 32'hDEADBEEF, 1'b1, e);
    total++; if (e !== 3) begin bad++; $display("FAIL wr_latency: got %0d edges want 3", e); end
    total++; if (cap_awaddr !== 8'h04 || cap_wdata !== 32'hDEADBEEF || cap_wstrb !== 4'hF) begin
      bad++; $display("FAIL wr_payload: addr=%h data=%h strb=%h want 04 deadbeef f", cap_awaddr, cap_wdata, cap_wstrb);
    end
    total++; if (aw_hi - aw0 !== 1 || b_hs - bh0 !== 1) begin
      bad++; $display("FAIL wr_beats: aw cycles=%0d b hs=%0d want 1 1", aw_hi - aw0, b_hs - bh0);
    end
    release_exec(f);
    total++; if (f !== 1'b0) begin bad++; $display("FAIL wr_fin_drop: got %b want 0", f); end
    $display("write 04 <= deadbeef: edges=%0d", e);
  endtask

  task automatic test_read();
    int e; logic f;
    run_cmd(8'h08, 32'h0, 1'b0, e);
    total++; if (e !== 3) begin bad++; $display("FAIL rd_latency: got %0d edges want 3", e); end
    total++; if (so_data !== 32'hCAFEF00D) begin bad++; $display("FAIL rd_data: got %h want cafef00d", so_data); end
    release_exec(f);
    total++; if (f !== 1'b0) begin bad++; $display("FAIL rd_fin_drop: got %b want 0", f); end
    run_cmd(8'h0C, 32'h12345678, 1'b1, e);
    release_exec(f);
    total++; if (so_data !== 32'hCAFEF00D) begin bad++; $display("FAIL rd_data_hold: got %h want cafef00d", so_data); end
    total++; if (mem[8'h0C] !== 32'h12345678) begin bad++; $display("FAIL wr_mem_0c: got %h want 12345678", mem[8'h0C]); end
    $display("read 08 => %h, then write 0c", so_data);
  endtask

  task automatic test_skew();
    int e; logic f; int aw0, w0, bh0, eb0;
    aw_d = 4; w_d = 1;
    aw0 = aw_hi; w0 = w_hi; bh0 = b_hs; eb0 = early_bready;
    run_cmd(8'h10, 32'hA5A5_0001, 1'b1, e);
    total++; if (e !== 6) begin bad++; $display("FAIL skew_latency: got %0d edges want 6", e); end
    total++; if (aw_hi - aw0 !== 4 || w_hi - w0 !== 1) begin
      bad++; $display("FAIL skew_valid_len: awvalid=%0d wvalid=%0d want 4 1", aw_hi - aw0, w_hi - w0);
    end
    total++; if (b_hs - bh0 !== 1 || early_bready - eb0 !== 0) begin
      bad++; $display("FAIL skew_b: b hs=%0d early bready=%0d want 1 0", b_hs - bh0, early_bready - eb0);
    end
    release_exec(f);
    aw_d = 1; w_d = 1;
    $display("skewed write 10: edges=%0d", e);
  endtask

  task automatic test_backpressure();
    int e; logic f; int br0, rr0;
    b_d = 5; br0 = bready_hi;
    run_cmd(8'h14, 32'h0BAD_F00D, 1'b1, e);
    total++; if (e !== 8) begin bad++; $display("FAIL bp_b_latency: got %0d edges want 8", e); end
    total++; if (bready_hi - br0 !== 6) begin bad++; $display("FAIL bp_bready_len: got %0d want 6", bready_hi - br0); end
    release_exec(f);
    b_d = 0; r_d = 3; rr0 = rready_hi;
    run_cmd(8'h0C, 32'h0, 1'b0, e);
    total++; if (e !== 6) begin bad++; $display("FAIL bp_r_latency: got %0d edges want 6", e); end
    total++; if (rready_hi - rr0 !== 4) begin bad++; $display("FAIL bp_rready_len: got %0d want 4", rready_hi - rr0); end
    total++; if (so_data !== 32'h12345678) begin bad++; $display("FAIL bp_rd_data: got %h want 12345678", so_data); end
    release_exec(f);
    r_d = 0;
    $display("backpressure: write 14, read 0c => %h", so_data);
  endtask

  task automatic test_reset_mid_read();
    int e; logic f;
    r_d = 10;
    @(negedge clk);
    si_address = 8'h08; we = 1'b0; exec = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rready !== 1'b1) begin bad++; $display("FAIL mid_rready_pre: got %b want 1", rready); end
    @(negedge clk); nreset = 1'b0; exec = 1'b0;
    @(posedge clk); #1;
    total++; if ({arvalid, rready, fin} !== 3'b000) begin
      bad++; $display("FAIL mid_reset_ctrl: got %b want 000", {arvalid, rready, fin});
    end
    total++; if (so_data !== 32'h0) begin bad++; $display("FAIL mid_reset_so_data: got %h want 0", so_data); end
    @(negedge clk); nreset = 1'b1; r_d = 0;
    run_cmd(8'h0C, 32'h0, 1'b0, e);
    total++; if (e !== 3 || so_data !== 32'h12345678) begin
      bad++; $display("FAIL mid_reset_reread: edges=%0d data=%h want 3 12345678", e, so_data);
    end
    release_exec(f);
    $display("reset during read, reread 0c => %h", so_data);
  endtask

`ifdef AXIL_SIMP_RESP_ERR_EN
  task automatic test_resp_err();
    int e; logic f;
    bresp_val = 2'b10;
    run_cmd(8'h20, 32'h1, 1'b1, e);
    total++; if (resp_err !== 2'b10) begin bad++; $display("FAIL resp_err_slverr: got %b want 10", resp_err); end
    release_exec(f);
    bresp_val = 2'b00; rresp_val = 2'b00;
    run_cmd(8'h08, 32'h0, 1'b0, e);
    total++; if (resp_err !== 2'b00) begin bad++; $display("FAIL resp_err_okay: got %b want 00", resp_err); end
    release_exec(f);
    $display("resp_err: slverr write then okay read");
  endtask
`endif

  task automatic test_protocol();
    total++; if (valid_drop !== 0) begin bad++; $display("FAIL valid_drop: got %0d want 0", valid_drop); end
    $display("protocol: valid drops=%0d", valid_drop);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h08] = 32'hCAFEF00D;
    test_reset();
    test_write();
    test_read();
    test_skew();
    test_backpressure();
    test_reset_mid_read();
`ifdef AXIL_SIMP_RESP_ERR_EN
    test_resp_err();
`endif
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
